// File: rtl/mips32_pkg.sv
// Shared mips32 definitions: datapath width, NOP encoding, reset PC default,
// fetch FSM state encoding, PC next-select codes and the IF/ID register layout.
// No ports; imported by the fetch stage files.
package mips32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP              = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instructions are word aligned; the low two address bits are always zero.
    localparam logic [XLEN-1:0] ALIGN_MASK       = 32'hFFFF_FFFC;

    typedef enum logic {
        FETCH         = 1'b0,
        REDIRECT_WAIT = 1'b1
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_TARGET = 2'd2,
        PC_PEND   = 2'd3
    } pc_sel_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP, pc4: '0, valid: 1'b0};

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the IF/ID
// register outputs. master = fetch_unit (drives imem_req/imem_addr/if_id_*),
// slave = memory + decode side (drives imem_rdata/imem_ready).
interface fetch_unit_if;
    import mips32_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_ready;
    logic [XLEN-1:0] if_id_instr;
    logic [XLEN-1:0] if_id_pc4;
    logic            if_id_valid;

    modport master (
        output imem_req, imem_addr, if_id_instr, if_id_pc4, if_id_valid,
        input  imem_rdata, imem_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_id_instr, if_id_pc4, if_id_valid,
        output imem_rdata, imem_ready
    );

endinterface

// File: rtl/fetch_unit_pc_register.sv
// Program counter flop with next-PC select (hold / +4 / target / pending target).
// Ports: clk, rst_n (async active-low), sel, target, pend_target in; pc, pc_plus4 out.
// Redirect addresses are word-aligned here so callers can pass raw targets.
module pc_register
    import mips32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  pc_sel_t         sel,
    input  logic [XLEN-1:0] target,
    input  logic [XLEN-1:0] pend_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    logic [XLEN-1:0] pc_next;

    // Modulo 2^32: 32'hFFFF_FFFC + 4 wraps to zero.
    assign pc_plus4 = pc + XLEN'(4);

    always_comb begin
        pc_next = pc;
        case (sel)
            PC_HOLD:   pc_next = pc;
            PC_INC:    pc_next = pc_plus4;
            PC_TARGET: pc_next = align_word(target);
            PC_PEND:   pc_next = align_word(pend_target);
            default:   pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// mips32 instruction fetch: owns the PC, drives imem, loads IF/ID; redirects on
// taken branches. All outputs registered; one instruction per cycle when not stalled.
// Backpressure: stall freezes everything; imem_ready=0 inserts bubbles.
// Ports: clk, rst_n, stall, is_branch, branch_target; bus (fetch_unit_if.master).
// Build option: define FETCH_DELAY_SLOT_EN to keep the instruction fetched
// alongside a redirect (MIPS delay slot) instead of squashing it.
module fetch_unit
    import mips32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              is_branch,
    input  logic [XLEN-1:0]   branch_target,
    fetch_unit_if.master      bus
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    pc_sel_t         pc_sel;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pend_target;
    logic [XLEN-1:0] pend_next;
    logic            req_q;
    logic            done;
    if_id_t          if_id;
    if_id_t          if_id_next;
    if_id_t          captured;

    // Request is registered so there is no input-to-output path; it rises on
    // the first edge after reset release and stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= 1'b0;
        end else begin
            req_q <= 1'b1;
        end
    end

    assign done     = req_q & bus.imem_ready;
    assign captured = '{instr: bus.imem_rdata, pc4: pc_plus4, valid: 1'b1};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    // A redirect that cannot retire the outstanding fetch parks in
    // REDIRECT_WAIT, keeping the old address on the bus until memory answers.
    always_comb begin
        state_next = state;
        if (!stall) begin
            case (state)
                FETCH:         if (is_branch && !done) state_next = REDIRECT_WAIT;
                REDIRECT_WAIT: if (done)               state_next = FETCH;
                default:       state_next = FETCH;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        pc_sel     = PC_HOLD;
        pend_next  = pend_target;
        if_id_next = if_id;
        if (!stall) begin
            if_id_next = IF_ID_BUBBLE;
            case (state)
                FETCH: begin
                    if (is_branch) begin
                        if (done) begin
                            pc_sel = PC_TARGET;
`ifdef FETCH_DELAY_SLOT_EN
                            if_id_next = captured;
`endif
                        end else begin
                            pend_next = branch_target;
                        end
                    end else if (done) begin
                        pc_sel     = PC_INC;
                        if_id_next = captured;
                    end
                end
                REDIRECT_WAIT: begin
                    // The newest taken branch wins over an older pending one,
                    // including when it arrives on the completing cycle.
                    if (is_branch) pend_next = branch_target;
                    if (done) begin
                        pc_sel = is_branch ? PC_TARGET : PC_PEND;
`ifdef FETCH_DELAY_SLOT_EN
                        if_id_next = captured;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id       <= IF_ID_BUBBLE;
            pend_target <= '0;
        end else begin
            if_id       <= if_id_next;
            pend_target <= pend_next;
        end
    end

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst_n       (rst_n),
        .sel         (pc_sel),
        .target      (branch_target),
        .pend_target (pend_target),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc;
    assign bus.if_id_instr = if_id.instr;
    assign bus.if_id_pc4   = if_id.pc4;
    assign bus.if_id_valid = if_id.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: event-level reference model compared every
// cycle, plus directed literal checks for reset, redirect, wait states, stall,
// PC wrap and reset during a pending redirect.
module tb_fetch_unit;
    import mips32_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0040;
`ifdef FETCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        is_branch = 1'b0;
    logic [31:0] branch_target = 32'h0;
    int          checks = 0;
    int          errors = 0;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .is_branch     (is_branch),
        .branch_target (branch_target),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a distinct nonzero word per address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign bus.imem_rdata = memfn(bus.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_req, m_valid, m_wait;
    logic [31:0] m_pc, m_pend, m_instr, m_pc4;

    always @(posedge clk or negedge rst_n) begin : model
        logic        done, redirect_now, keep;
        if (!rst_n) begin
            m_req = 1'b0; m_pc = RST_PC; m_valid = 1'b0; m_instr = 32'h0;
            m_pc4 = 32'h0; m_wait = 1'b0; m_pend = 32'h0;
        end else begin
            done = m_req && bus.imem_ready;
            if (!stall) begin
                // A completion while a redirect is taken or pending is wrong-path.
                redirect_now = m_wait || is_branch;
                keep         = done && (!redirect_now || DS);
                m_valid      = keep;
                m_instr      = keep ? memfn(m_pc) : 32'h0;
                m_pc4        = m_pc + 32'd4;
                if (is_branch) m_pend = branch_target & 32'hFFFF_FFFC;
                if (done) begin
                    m_pc   = redirect_now ? m_pend : m_pc + 32'd4;
                    m_wait = 1'b0;
                end else if (redirect_now) begin
                    m_wait = 1'b1;
                end
            end
            m_req = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_req",   32'(bus.imem_req),    32'(m_req));
            chk("model_addr",  bus.imem_addr,        m_pc);
            chk("model_valid", 32'(bus.if_id_valid), 32'(m_valid));
            chk("model_instr", bus.if_id_instr,      m_instr);
            if (m_valid) chk("model_pc4", bus.if_id_pc4, m_pc4);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        bus.imem_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_addr",  bus.imem_addr,        32'h40);
        chk("rst_req",   32'(bus.imem_req),    32'h0);
        chk("rst_valid", 32'(bus.if_id_valid), 32'h0);
        chk("rst_instr", bus.if_id_instr,      32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("boot_addr0", bus.imem_addr, 32'h40);
        chk("boot_req",   32'(bus.imem_req), 32'h1);
        cyc(1);
        chk("boot_addr1", bus.imem_addr, 32'h44);
        chk("boot_pc4_1", bus.if_id_pc4, 32'h44);
        chk("boot_instr", bus.if_id_instr, 32'h0040_FFBF);
        cyc(1);
        chk("boot_addr2", bus.imem_addr, 32'h48);
        chk("boot_pc4_2", bus.if_id_pc4, 32'h48);

        // Redirect to an unaligned target: low bits dropped.
        is_branch = 1'b1; branch_target = 32'h0000_0023;
        cyc(1);
        chk("align_addr", bus.imem_addr, 32'h20);

        // Taken branch on a done cycle at PC=0x20.
        branch_target = 32'h0000_0100;
        cyc(1);
        is_branch = 1'b0;
        chk("br_addr", bus.imem_addr, 32'h100);
        if (DS) begin
            chk("br_ds_valid", 32'(bus.if_id_valid), 32'h1);
            chk("br_ds_pc4",   bus.if_id_pc4,        32'h24);
        end else begin
            chk("br_squash_valid", 32'(bus.if_id_valid), 32'h0);
        end

        // Branch while memory is stalled: old address held until it completes.
        bus.imem_ready = 1'b0; is_branch = 1'b1; branch_target = 32'h0000_0200;
        cyc(1);
        is_branch = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wait_addr",  bus.imem_addr,        32'h100);
            chk("wait_valid", 32'(bus.if_id_valid), 32'h0);
            if (i < 2) cyc(1);
        end
        bus.imem_ready = 1'b1;
        cyc(1);
        chk("wait_redirect_addr", bus.imem_addr, 32'h200);
        if (DS) begin
            chk("wait_ds_valid", 32'(bus.if_id_valid), 32'h1);
            chk("wait_ds_pc4",   bus.if_id_pc4,        32'h104);
        end else begin
            chk("wait_squash_valid", 32'(bus.if_id_valid), 32'h0);
        end

        // Stall with a done and a branch: everything frozen, branch ignored.
        stall = 1'b1; is_branch = 1'b1; branch_target = 32'h0000_0300;
        for (int i = 0; i < 2; i++) begin
            cyc(1);
            chk("stall_addr",  bus.imem_addr,        32'h200);
            chk("stall_valid", 32'(bus.if_id_valid), 32'(DS));
            if (DS) chk("stall_pc4", bus.if_id_pc4, 32'h104);
        end
        stall = 1'b0; is_branch = 1'b0;
        cyc(1);
        chk("resume_addr",  bus.imem_addr,        32'h204);
        chk("resume_pc4",   bus.if_id_pc4,        32'h204);
        chk("resume_instr", bus.if_id_instr,      32'h0200_FDFF);
        chk("resume_valid", 32'(bus.if_id_valid), 32'h1);

        // PC wrap at the top of the address space.
        is_branch = 1'b1; branch_target = 32'hFFFF_FFFC;
        cyc(1);
        is_branch = 1'b0;
        chk("wrap_pre_addr", bus.imem_addr, 32'hFFFF_FFFC);
        cyc(1);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_pc4",  bus.if_id_pc4, 32'h0);

        // Reset in the middle of a pending redirect.
        bus.imem_ready = 1'b0; is_branch = 1'b1; branch_target = 32'h0000_0500;
        cyc(1);
        is_branch = 1'b0;
        chk("rw_addr", bus.imem_addr, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("rw_rst_addr",  bus.imem_addr,        32'h40);
        chk("rw_rst_req",   32'(bus.imem_req),    32'h0);
        chk("rw_rst_valid", 32'(bus.if_id_valid), 32'h0);
        chk("rw_rst_instr", bus.if_id_instr,      32'h0);
        chk("rw_rst_pc4",   bus.if_id_pc4,        32'h0);
        bus.imem_ready = 1'b1;
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        chk("rw_rst_resume", bus.imem_addr, 32'h44);

        // Mixed traffic, checked by the model each cycle.
        for (int i = 0; i < 300; i++) begin
            stall          = ($urandom_range(0, 4) == 0);
            is_branch      = ($urandom_range(0, 4) == 0);
            branch_target  = $urandom;
            bus.imem_ready = ($urandom_range(0, 3) != 0);
            if (i == 150) branch_target = 32'hFFFF_FFF8;
            cyc(1);
        end
        stall = 1'b0; is_branch = 1'b0; bus.imem_ready = 1'b1;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
